// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data memory controller.
// Contents: size encodings, FSM state enum, latched request struct and
// the byte-enable helper that maps (size, addr[1:0]) onto the four byte lanes.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] wdata;
  } dmem_req_t;

  // Little-endian lane enables; the illegal size gives no lanes.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      SZ_BYTE: be = 4'b0001 << lo;
      SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Load/store bus between the MEM stage (master) and the data memory (slave).
// Request: req, we, addr, size, sign_ext, wdata.
// Response: rdata, ready (one-cycle strobe), err, busy.
interface data_mem_ctrl_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;

  modport master (output req, we, addr, size, sign_ext, wdata,
                  input  rdata, ready, err, busy);
  modport slave  (input  req, we, addr, size, sign_ext, wdata,
                  output rdata, ready, err, busy);
endinterface

// File: rtl/dmem_byte_ram.sv
// Single-port word RAM with per-byte write enables.
// Ports: clk, rd_en (registered read), wr_en + be (byte-lane write),
// idx (word index), wdata (lane-replicated store data), rdata (read register).
module dmem_byte_ram #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic          wr_en,
  input  logic [3:0]    be,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
    // Read register holds between reads so the response stays stable.
    if (rd_en) rdata <= mem[idx];
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller for the CPU load/store path.
// Ports: clk, reset (sync, active high), bus (slave side of data_mem_ctrl_if).
// Accepts one request in IDLE, waits WAIT_CYCLES, then strobes ready for one
// cycle with rdata/err. The RAM is touched only on the edge entering RESP.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1,
  parameter int DATA_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  data_mem_ctrl_if.slave   bus
);

  if (DATA_W != 32) begin : g_bad_width
    $error("data_mem_ctrl supports DATA_W=32 only");
  end

  localparam int AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  dmem_req_t        req_q, acc;
  logic             busy, ready, err_q, acc_err, go_resp;
  logic [31:0]      rdata_hold, rdata_cur, ram_q, wdata_rep;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;

  // The request acted on at the edge entering RESP: the live bus when the
  // response follows acceptance directly (WAIT_CYCLES=0), else the latched one.
  always_comb begin
    acc = req_q;
    if (state == ST_IDLE) acc = '{we: bus.we, addr: bus.addr, size: bus.size,
                                  sign_ext: bus.sign_ext, wdata: bus.wdata};
  end

  always_comb begin
    acc_err = 1'b0;
    if ({2'b00, acc.addr[31:2]} >= 32'(DEPTH_WORDS))  acc_err = 1'b1;
    if (acc.size == 2'b11)                            acc_err = 1'b1;
    if (acc.size == SZ_HALF && acc.addr[0])           acc_err = 1'b1;
    if (acc.size == SZ_WORD && acc.addr[1:0] != 2'b0) acc_err = 1'b1;
  end

  // Reset in the same cycle suppresses the RAM access, so an aborted store
  // never commits.
  assign go_resp = !reset &&
                   ((state == ST_IDLE && bus.req && WAIT_CYCLES == 0) ||
                    (state == ST_WAIT && cnt == '0));

  always_comb begin
    wdata_rep = acc.wdata;
    case (acc.size)
      SZ_BYTE: wdata_rep = {4{acc.wdata[7:0]}};
      SZ_HALF: wdata_rep = {2{acc.wdata[15:0]}};
      default: wdata_rep = acc.wdata;
    endcase
  end

  dmem_byte_ram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_ram (
    .clk   (clk),
    .rd_en (go_resp && !acc.we && !acc_err),
    .wr_en (go_resp &&  acc.we && !acc_err),
    .be    (byte_en(acc.size, acc.addr[1:0])),
    .idx   (acc.addr[AW+1:2]),
    .wdata (wdata_rep),
    .rdata (ram_q)
  );

  // Lane select and extension of the RAM word, valid in RESP.
  assign ld_byte = ram_q[8*req_q.addr[1:0] +: 8];
  assign ld_half = req_q.addr[1] ? ram_q[31:16] : ram_q[15:0];

  always_comb begin
    rdata_cur = '0;
    if (!err_q && !req_q.we) begin
      case (req_q.size)
        SZ_BYTE: rdata_cur = {{24{req_q.sign_ext & ld_byte[7]}}, ld_byte};
        SZ_HALF: rdata_cur = {{16{req_q.sign_ext & ld_half[15]}}, ld_half};
        default: rdata_cur = ram_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      ready      <= 1'b0;
      err_q      <= 1'b0;
      rdata_hold <= '0;
    end else begin
      ready <= 1'b0;
      case (state)
        ST_IDLE: if (bus.req) begin
          req_q <= acc;
          if (WAIT_CYCLES > 0) begin
            state <= ST_WAIT;
            cnt   <= CNT_INIT;
            busy  <= 1'b1;
          end else begin
            state <= ST_RESP;
            ready <= 1'b1;
            err_q <= acc_err;
          end
        end
        ST_WAIT: if (cnt == '0) begin
          state <= ST_RESP;
          busy  <= 1'b0;
          ready <= 1'b1;
          err_q <= acc_err;
        end else begin
          cnt <= cnt - 1'b1;
        end
        ST_RESP: begin
          // Freeze the response so rdata holds until the next RESP.
          state      <= ST_IDLE;
          rdata_hold <= rdata_cur;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready = ready;
  assign bus.busy  = busy;
  assign bus.err   = err_q;
  assign bus.rdata = ready ? rdata_cur : rdata_hold;

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  data_mem_ctrl_if b0 ();
  data_mem_ctrl_if b1 ();
  data_mem_ctrl_if b3 ();

  data_mem_ctrl #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (.clk(clk), .reset(reset), .bus(b0.slave));
  data_mem_ctrl #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));
  data_mem_ctrl #(.DEPTH_WORDS(256), .WAIT_CYCLES(3)) dut3 (.clk(clk), .reset(reset), .bus(b3.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic set_fields(input logic w, input logic [31:0] a, input logic [1:0] sz,
                            input logic sx, input logic [31:0] wd);
    b0.we = w; b0.addr = a; b0.size = sz; b0.sign_ext = sx; b0.wdata = wd;
    b1.we = w; b1.addr = a; b1.size = sz; b1.sign_ext = sx; b1.wdata = wd;
    b3.we = w; b3.addr = a; b3.size = sz; b3.sign_ext = sx; b3.wdata = wd;
  endtask

  task automatic set_req(input int which, input logic r);
    case (which)
      0:       b0.req = r;
      1:       b1.req = r;
      default: b3.req = r;
    endcase
  endtask

  function automatic logic rdy(input int which);
    return (which == 0) ? b0.ready : (which == 1) ? b1.ready : b3.ready;
  endfunction
  function automatic logic [31:0] rdv(input int which);
    return (which == 0) ? b0.rdata : (which == 1) ? b1.rdata : b3.rdata;
  endfunction
  function automatic logic erv(input int which);
    return (which == 0) ? b0.err : (which == 1) ? b1.err : b3.err;
  endfunction

  // One request; lat counts clock edges from the accepting edge (=1) to the
  // edge after which ready is seen high. Bounded at 20.
  task automatic do_acc(input int which, input logic w, input logic [31:0] a, input logic [1:0] sz,
                        input logic sx, input logic [31:0] wd,
                        output logic [31:0] rdo, output logic eo, output int lat);
    @(posedge clk); #1;
    set_fields(w, a, sz, sx, wd);
    set_req(which, 1'b1);
    @(posedge clk); #1;
    set_req(which, 1'b0);
    lat = 1;
    while (!rdy(which) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rdo = rdv(which);
    eo  = erv(which);
  endtask

  task automatic acc1(input string tag, input logic w, input logic [31:0] a, input logic [1:0] sz,
                      input logic sx, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] r;
    logic e;
    int lat;
    do_acc(1, w, a, sz, sx, wd, r, e, lat);
    chk({tag, "/lat"}, 32'(lat), 32'd2);
    chk({tag, "/rdata"}, r, exp_rd);
    chk({tag, "/err"}, {31'b0, e}, {31'b0, exp_err});
  endtask

  initial begin
    logic [31:0] r;
    logic e;
    int lat;
    int n0, n3, f0, s0, f3, s3, stray;

    reset = 1'b1;
    set_req(0, 1'b0); set_req(1, 1'b0); set_req(3, 1'b0);
    set_fields(1'b0, 32'h0, SZ_WORD, 1'b0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst/ready1", {31'b0, b1.ready}, 32'd0);
    chk("rst/err1",   {31'b0, b1.err},   32'd0);
    chk("rst/busy1",  {31'b0, b1.busy},  32'd0);
    chk("rst/rdata1", b1.rdata, 32'h0);
    chk("rst/rdata0", b0.rdata, 32'h0);
    chk("rst/rdata3", b3.rdata, 32'h0);
    reset = 1'b0;

    // Word store/load and lane updates (WAIT_CYCLES=1).
    acc1("st_w10",  1'b1, 32'h10, SZ_WORD, 1'b0, 32'h12345678, 32'h0, 1'b0);
    acc1("ld_w10",  1'b0, 32'h10, SZ_WORD, 1'b1, 32'h0, 32'h12345678, 1'b0);
    @(posedge clk); #1;
    chk("hold/ready", {31'b0, b1.ready}, 32'd0);
    chk("hold/rdata", b1.rdata, 32'h12345678);
    acc1("st_b11",  1'b1, 32'h11, SZ_BYTE, 1'b0, 32'h555555AB, 32'h0, 1'b0);
    acc1("ld_w10b", 1'b0, 32'h10, SZ_WORD, 1'b0, 32'h0, 32'h1234AB78, 1'b0);
    acc1("ld_b11s", 1'b0, 32'h11, SZ_BYTE, 1'b1, 32'h0, 32'hFFFFFFAB, 1'b0);
    acc1("ld_b11z", 1'b0, 32'h11, SZ_BYTE, 1'b0, 32'h0, 32'h000000AB, 1'b0);
    acc1("st_h12",  1'b1, 32'h12, SZ_HALF, 1'b0, 32'h77778001, 32'h0, 1'b0);
    acc1("ld_w10h", 1'b0, 32'h10, SZ_WORD, 1'b0, 32'h0, 32'h8001AB78, 1'b0);
    acc1("ld_h12s", 1'b0, 32'h12, SZ_HALF, 1'b1, 32'h0, 32'hFFFF8001, 1'b0);
    acc1("ld_h10s", 1'b0, 32'h10, SZ_HALF, 1'b1, 32'h0, 32'hFFFFAB78, 1'b0);
    acc1("ld_h10z", 1'b0, 32'h10, SZ_HALF, 1'b0, 32'h0, 32'h0000AB78, 1'b0);
    acc1("ld_b13z", 1'b0, 32'h13, SZ_BYTE, 1'b0, 32'h0, 32'h00000080, 1'b0);
    acc1("st_w00",  1'b1, 32'h00, SZ_WORD, 1'b0, 32'hCAFEF00D, 32'h0, 1'b0);

    // Rejected accesses: err with ready, rdata 0, RAM untouched.
    acc1("e_ld_w13", 1'b0, 32'h13, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b1);
    @(posedge clk); #1;
    chk("e_hold/err", {31'b0, b1.err}, 32'd1);
    acc1("e_st_400", 1'b1, 32'h400, SZ_WORD, 1'b0, 32'hBADBAD00, 32'h0, 1'b1);
    acc1("ld_w00",   1'b0, 32'h00, SZ_WORD, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0);
    acc1("e_sz11",   1'b1, 32'h10, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1);
    acc1("e_st_h11", 1'b1, 32'h11, SZ_HALF, 1'b0, 32'h0000FFFF, 32'h0, 1'b1);
    acc1("ld_w10e",  1'b0, 32'h10, SZ_WORD, 1'b0, 32'h0, 32'h8001AB78, 1'b0);

    // Latency for WAIT_CYCLES=0 and 3.
    do_acc(0, 1'b1, 32'h20, SZ_WORD, 1'b0, 32'hA5A5C3C3, r, e, lat);
    chk("w0_st/lat", 32'(lat), 32'd1);
    do_acc(0, 1'b0, 32'h20, SZ_WORD, 1'b0, 32'h0, r, e, lat);
    chk("w0_ld/lat", 32'(lat), 32'd1);
    chk("w0_ld/rdata", r, 32'hA5A5C3C3);
    do_acc(3, 1'b1, 32'h24, SZ_WORD, 1'b0, 32'h0BADF00D, r, e, lat);
    chk("w3_st/lat", 32'(lat), 32'd4);
    do_acc(3, 1'b0, 32'h26, SZ_HALF, 1'b1, 32'h0, r, e, lat);
    chk("w3_ld/lat", 32'(lat), 32'd4);
    chk("w3_ld/rdata", r, 32'h00000BAD);

    // req held high: one response every WAIT_CYCLES+2 cycles.
    @(posedge clk); #1;
    set_fields(1'b0, 32'h20, SZ_WORD, 1'b0, 32'h0);
    set_req(0, 1'b1); set_req(3, 1'b1);
    n0 = 0; n3 = 0; f0 = -1; s0 = -1; f3 = -1; s3 = -1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (b0.ready) begin
        if (n0 == 0) f0 = c; else if (n0 == 1) s0 = c;
        n0++;
      end
      if (b3.ready) begin
        if (n3 == 0) f3 = c; else if (n3 == 1) s3 = c;
        n3++;
      end
    end
    set_req(0, 1'b0); set_req(3, 1'b0);
    chk("tp0/count",   32'(n0), 32'd10);
    chk("tp0/spacing", 32'(s0 - f0), 32'd2);
    chk("tp3/count",   32'(n3), 32'd4);
    chk("tp3/spacing", 32'(s3 - f3), 32'd5);
    repeat (6) @(posedge clk);

    // Reset while in WAIT aborts the pending store.
    acc1("st_w20", 1'b1, 32'h20, SZ_WORD, 1'b0, 32'h11223344, 32'h0, 1'b0);
    @(posedge clk); #1;
    set_fields(1'b1, 32'h20, SZ_WORD, 1'b0, 32'hDEADBEEF);
    set_req(1, 1'b1);
    @(posedge clk); #1;
    set_req(1, 1'b0);
    chk("abort/busy_wait", {31'b0, b1.busy}, 32'd1);
    chk("abort/ready_wait", {31'b0, b1.ready}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort/busy_rst", {31'b0, b1.busy}, 32'd0);
    stray = 0;
    if (b1.ready) stray++;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (b1.ready) stray++;
    end
    chk("abort/no_ready", 32'(stray), 32'd0);
    chk("abort/busy_idle", {31'b0, b1.busy}, 32'd0);
    acc1("ld_w20", 1'b0, 32'h20, SZ_WORD, 1'b0, 32'h0, 32'h11223344, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
